// File: rtl/button_debounce_multi_if.sv
// Raw button pins plus the debounced level/event outputs of one button bank.
interface button_debounce_multi_if #(
    parameter int N = 4
);
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;
    logic [N-1:0] btn_repeat;
    logic         sample_tick;

    modport master (
        output btn_raw,
        input  btn_level, btn_press, btn_release, btn_repeat, sample_tick
    );

    modport slave (
        input  btn_raw,
        output btn_level, btn_press, btn_release, btn_repeat, sample_tick
    );
endinterface

// File: rtl/button_debounce_multi.sv
// N-channel button debouncer: sync, sampled saturating integrator with hysteresis,
// press/release pulses, optional auto-repeat, and a power-up lockout.
module button_debounce_lane #(
    parameter int CNT_W      = 4,
    parameter int REPEAT_EN  = 1,
    parameter int HOLD_TICKS = 384,
    parameter int RATE_TICKS = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic s,
    input  logic en,
    output logic level,
    output logic press,
    output logic rel,
    output logic rpt
);
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic [CNT_W-1:0] cnt;
    logic             level_next;

    // Level only moves at the rails; anywhere in between it holds.
    always_comb begin
        level_next = level;
        if (en) begin
            if (cnt == CMAX)
                level_next = 1'b1;
            else if (cnt == '0)
                level_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            if (en) begin
                if (s && cnt != CMAX)
                    cnt <= cnt + 1'b1;
                else if (!s && cnt != '0)
                    cnt <= cnt - 1'b1;
            end
            level <= level_next;
            press <= level_next & ~level;
            rel   <= ~level_next & level;
        end
    end

    generate
        if (REPEAT_EN != 0) begin : g_rpt
            localparam int HW = $clog2(HOLD_TICKS + 1);
            localparam logic [HW-1:0] HOLD   = HW'(HOLD_TICKS);
            localparam logic [HW-1:0] RELOAD = HW'(HOLD_TICKS - RATE_TICKS);

            logic [HW-1:0] hold;
            logic [HW-1:0] hold_inc;

            assign hold_inc = hold + 1'b1;

            // Gating on the registered level skips the tick that set it; gating on
            // level_next kills any repeat on the tick that releases.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    hold <= '0;
                    rpt  <= 1'b0;
                end else begin
                    rpt <= 1'b0;
                    if (!level_next) begin
                        hold <= '0;
                    end else if (en && level) begin
                        if (hold_inc == HOLD) begin
                            rpt  <= 1'b1;
                            hold <= RELOAD;
                        end else begin
                            hold <= hold_inc;
                        end
                    end
                end
            end
        end else begin : g_norpt
            logic unused_repeat_cfg;
            assign unused_repeat_cfg = (HOLD_TICKS == RATE_TICKS);
            assign rpt = 1'b0;
        end
    endgenerate
endmodule

module button_debounce_multi #(
    parameter int N          = 4,
    parameter int ACTIVE_LOW = 0,
    parameter int DIV_MAX    = 32768,
    parameter int CNT_W      = 4,
    parameter int REPEAT_EN  = 1,
    parameter int HOLD_TICKS = 384,
    parameter int RATE_TICKS = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    button_debounce_multi_if.slave bus
);
    localparam int DW = $clog2(DIV_MAX);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV_MAX - 1);

    logic [DW-1:0] div_cnt;
    logic          tick;
    logic          en;
    logic [N-1:0]  raw_c;
    logic [N-1:0]  sync1;
    logic [N-1:0]  s;
    logic [1:0]    vld_pipe;
    logic          lockout;

    logic [N-1:0]  level_v;
    logic [N-1:0]  press_v;
    logic [N-1:0]  rel_v;
    logic [N-1:0]  rpt_v;

    assign raw_c = (ACTIVE_LOW != 0) ? ~bus.btn_raw : bus.btn_raw;
    assign tick  = (div_cnt == DIV_LAST);
    assign en    = tick & ~lockout;

    // vld_pipe keeps lockout from clearing on the reset-zeroed synchroniser
    // before real pin samples have reached s.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            sync1    <= '0;
            s        <= '0;
            vld_pipe <= '0;
            lockout  <= 1'b1;
        end else begin
            div_cnt  <= tick ? '0 : div_cnt + 1'b1;
            sync1    <= raw_c;
            s        <= sync1;
            vld_pipe <= {vld_pipe[0], 1'b1};
            if (vld_pipe[1] && !(|s))
                lockout <= 1'b0;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        button_debounce_lane #(
            .CNT_W      (CNT_W),
            .REPEAT_EN  (REPEAT_EN),
            .HOLD_TICKS (HOLD_TICKS),
            .RATE_TICKS (RATE_TICKS)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .s     (s[i]),
            .en    (en),
            .level (level_v[i]),
            .press (press_v[i]),
            .rel   (rel_v[i]),
            .rpt   (rpt_v[i])
        );
    end

    assign bus.btn_level   = level_v;
    assign bus.btn_press   = press_v;
    assign bus.btn_release = rel_v;
    assign bus.btn_repeat  = rpt_v;
    assign bus.sample_tick = tick;
endmodule

// File: tb/tb_button_debounce_multi.sv
// Directed bench: vector table for a clean press/release, hand sequences for bounce,
// lockout, auto-repeat, active-low pins and mid-run reset.
module tb_button_debounce_multi;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    button_debounce_multi_if #(.N(4)) ifa ();
    button_debounce_multi_if #(.N(4)) ifr ();
    button_debounce_multi_if #(.N(4)) ifl ();

    button_debounce_multi #(.N(4), .ACTIVE_LOW(0), .DIV_MAX(4), .CNT_W(2),
        .REPEAT_EN(0), .HOLD_TICKS(8), .RATE_TICKS(3))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    button_debounce_multi #(.N(4), .ACTIVE_LOW(0), .DIV_MAX(4), .CNT_W(2),
        .REPEAT_EN(1), .HOLD_TICKS(8), .RATE_TICKS(3))
        dut_r (.clk(clk), .rst_n(rst_n), .bus(ifr));
    button_debounce_multi #(.N(4), .ACTIVE_LOW(1), .DIV_MAX(4), .CNT_W(2),
        .REPEAT_EN(0), .HOLD_TICKS(8), .RATE_TICKS(3))
        dut_l (.clk(clk), .rst_n(rst_n), .bus(ifl));

    typedef struct {
        logic [3:0] raw;
        logic [3:0] level;
        logic [3:0] press;
        logic [3:0] rel;
        logic       tick;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] ra, input logic [3:0] rr, input logic [3:0] rl);
        rst_n = 1'b0;
        ifa.btn_raw = ra;
        ifr.btn_raw = rr;
        ifl.btn_raw = rl;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [3:0] act_a();
        return ifa.btn_level | ifa.btn_press | ifa.btn_release | ifa.btn_repeat;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv [1:38];
        int   npress, pcyc, nlvl, nother, nrel, rcyc, nact;
        logic [3:0] pvec;
        logic prev;
        int   rep_q[$];
        int   exp_rep[5];

        // ---------------- reset state ----------------
        do_reset(4'b0000, 4'b0000, 4'b1111);
        check("rst a outputs", {act_a(), 3'b0, ifa.sample_tick}, 8'h00);
        check("rst r outputs", {ifr.btn_level | ifr.btn_press | ifr.btn_release | ifr.btn_repeat,
                                3'b0, ifr.sample_tick}, 8'h00);
        check("rst l outputs", {ifl.btn_level | ifl.btn_press | ifl.btn_release | ifl.btn_repeat,
                                3'b0, ifl.sample_tick}, 8'h00);

        // ---------------- test 1: clean press / release table ----------------
        for (int k = 1; k <= 38; k++) begin
            tv[k].raw   = (k >= 5 && k <= 21) ? 4'b0001 : 4'b0000;
            tv[k].level = (k >= 20 && k < 36) ? 4'b0001 : 4'b0000;
            tv[k].press = (k == 20) ? 4'b0001 : 4'b0000;
            tv[k].rel   = (k == 36) ? 4'b0001 : 4'b0000;
            tv[k].tick  = (k % 4 == 3);
        end
        do_reset(4'b0000, 4'b0000, 4'b1111);
        for (int k = 1; k <= 38; k++) begin
            ifa.btn_raw = tv[k].raw;
            step();
            check($sformatf("t1 level k=%0d", k), ifa.btn_level, tv[k].level);
            check($sformatf("t1 press k=%0d", k), ifa.btn_press, tv[k].press);
            check($sformatf("t1 release k=%0d", k), ifa.btn_release, tv[k].rel);
            check($sformatf("t1 tick k=%0d", k), ifa.sample_tick, tv[k].tick);
            check($sformatf("t1 repeat k=%0d", k), ifa.btn_repeat, 4'b0000);
        end

        // ---------------- test 2: bounce on channel 1 ----------------
        do_reset(4'b0000, 4'b0000, 4'b1111);
        npress = 0; pcyc = -1; nlvl = 0; nother = 0; nrel = 0; prev = 1'b0;
        for (int k = 1; k <= 90; k++) begin
            if (k < 7)        ifa.btn_raw = 4'b0000;
            else if (k <= 46) ifa.btn_raw = (((k - 7) / 3) % 2 == 0) ? 4'b0010 : 4'b0000;
            else              ifa.btn_raw = 4'b0010;
            step();
            if (ifa.btn_press[1]) begin npress++; pcyc = k; end
            if (ifa.btn_release[1]) nrel++;
            if (ifa.btn_level[1] !== prev) nlvl++;
            prev = ifa.btn_level[1];
            if ((act_a() & 4'b1101) != 4'b0000) nother++;
        end
        check("t2 press count", npress, 1);
        check("t2 press cycle", pcyc, 64);
        check("t2 level changes", nlvl, 1);
        check("t2 release count", nrel, 0);
        check("t2 final level", ifa.btn_level, 4'b0010);
        check("t2 other channels", nother, 0);

        // ---------------- test 3: lockout with buttons held through reset ----------------
        do_reset(4'b1010, 4'b0000, 4'b1111);
        nact = 0;
        for (int k = 1; k <= 100; k++) begin
            ifa.btn_raw = 4'b1010;
            step();
            if (act_a() != 4'b0000) nact++;
        end
        check("t3 locked activity", nact, 0);
        pcyc = -1; pvec = 4'b0000; nother = 0;
        for (int k = 101; k <= 130; k++) begin
            ifa.btn_raw = (k >= 105) ? 4'b1000 : 4'b0000;
            step();
            if (ifa.btn_press != 4'b0000 && pcyc < 0) begin pcyc = k; pvec = ifa.btn_press; end
            if ((act_a() & 4'b0111) != 4'b0000) nother++;
        end
        check("t3 press cycle", pcyc, 120);
        check("t3 press vector", pvec, 4'b1000);
        check("t3 final level", ifa.btn_level, 4'b1000);
        check("t3 other channels", nother, 0);

        // ---------------- test 4: auto-repeat on channel 2 ----------------
        do_reset(4'b0000, 4'b0000, 4'b1111);
        npress = 0; pcyc = -1; nrel = 0; rcyc = -1; nother = 0;
        for (int k = 1; k <= 150; k++) begin
            ifr.btn_raw = (k >= 5 && k < 90) ? 4'b0100 : 4'b0000;
            step();
            if (ifr.btn_press != 4'b0000) begin npress++; pcyc = k; end
            if (ifr.btn_release != 4'b0000) begin nrel++; rcyc = k; end
            if (ifr.btn_repeat != 4'b0000) rep_q.push_back(k);
            if (((ifr.btn_press | ifr.btn_release | ifr.btn_repeat | ifr.btn_level) & 4'b1011) != 4'b0000)
                nother++;
        end
        exp_rep = '{52, 64, 76, 88, 100};
        check("t4 press count", npress, 1);
        check("t4 press cycle", pcyc, 20);
        check("t4 repeat count", rep_q.size(), 5);
        for (int i = 0; i < 5; i++)
            check($sformatf("t4 repeat %0d cycle", i), (i < rep_q.size()) ? rep_q[i] : -1, exp_rep[i]);
        check("t4 release count", nrel, 1);
        check("t4 release cycle", rcyc, 104);
        check("t4 other channels", nother, 0);

        // ---------------- test 5: active-low pins ----------------
        do_reset(4'b0000, 4'b0000, 4'b1111);
        nact = 0; pcyc = -1; pvec = 4'b0000;
        for (int k = 1; k <= 70; k++) begin
            ifl.btn_raw = (k <= 40) ? 4'b1111 : 4'b1110;
            step();
            if (k <= 40 && (ifl.btn_level | ifl.btn_press | ifl.btn_release) != 4'b0000) nact++;
            if (ifl.btn_press != 4'b0000 && pcyc < 0) begin pcyc = k; pvec = ifl.btn_press; end
        end
        check("t5 idle activity", nact, 0);
        check("t5 press cycle", pcyc, 56);
        check("t5 press vector", pvec, 4'b0001);
        check("t5 final level", ifl.btn_level, 4'b0001);

        // ---------------- test 6: reset while buttons are down ----------------
        do_reset(4'b0000, 4'b0000, 4'b1111);
        for (int k = 1; k <= 22; k++) begin
            ifa.btn_raw = (k >= 5) ? 4'b0101 : 4'b0000;
            step();
        end
        check("t6 level before reset", ifa.btn_level, 4'b0101);
        rst_n = 1'b0;
        step();
        check("t6 level after reset", ifa.btn_level, 4'b0000);
        check("t6 release after reset", ifa.btn_release, 4'b0000);
        check("t6 press after reset", ifa.btn_press, 4'b0000);
        check("t6 tick after reset", ifa.sample_tick, 1'b0);
        rst_n = 1'b1;
        nact = 0; pcyc = -1; pvec = 4'b0000;
        for (int k = 1; k <= 85; k++) begin
            ifa.btn_raw = (k <= 60 || k >= 65) ? 4'b0101 : 4'b0000;
            step();
            if (k <= 60 && act_a() != 4'b0000) nact++;
            if (ifa.btn_press != 4'b0000 && pcyc < 0) begin pcyc = k; pvec = ifa.btn_press; end
        end
        check("t6 relocked activity", nact, 0);
        check("t6 re-press cycle", pcyc, 80);
        check("t6 re-press vector", pvec, 4'b0101);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
